// File: rtl/uart_pkg.sv
// Shared encodings, ASCII constants and hex helper for the LED value UART reporter.
package uart_pkg;

  typedef enum logic [1:0] {
    L_IDLE,
    L_LOAD,
    L_BYTE_WAIT,
    L_FINISH
  } line_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) return ASCII_ZERO + n8;
    else           return ASCII_A + (n8 - 8'd10);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first; owns the baud counter and shift register.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_t      state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [2:0]       bit_idx, nbit;
  logic [7:0]       shreg, nsh;
  logic             tx_q, ntx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= nstate;
      cnt     <= ncnt;
      bit_idx <= nbit;
      shreg   <= nsh;
      tx_q    <= ntx;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nbit   = bit_idx;
    nsh    = shreg;
    ntx    = tx_q;
    unique case (state)
      B_IDLE: begin
        ntx  = 1'b1;
        ncnt = '0;
        if (start) begin
          nstate = B_START;
          nsh    = data;
          nbit   = '0;
          ntx    = 1'b0;
        end
      end
      B_START: begin
        if (cnt == CNT_MAX) begin
          ncnt   = '0;
          nstate = B_DATA;
          ntx    = shreg[0];
          nsh    = {1'b0, shreg[7:1]};
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt == CNT_MAX) begin
          ncnt = '0;
          if (bit_idx == 3'd7) begin
            nstate = B_STOP;
            ntx    = 1'b1;
          end else begin
            nbit = bit_idx + 1'b1;
            ntx  = shreg[0];
            nsh  = {1'b0, shreg[7:1]};
          end
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt == CNT_MAX) begin
          ncnt   = '0;
          nstate = B_IDLE;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      default: nstate = B_IDLE;
    endcase
  end

  // busy drops during the last stop-bit cycle so the line FSM can reissue with a 2-cycle gap
  assign busy = (state != B_IDLE) && !((state == B_STOP) && (cnt == CNT_MAX));
  assign tx   = tx_q;

endmodule

// File: rtl/led_value_uart_tx.sv
// Reports the LED counter value as "HH\r\n" over the UART; holds the message latch and line FSM.
module led_value_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             send,
  output logic             busy,
  output logic             done,
  output logic             tx
);

  line_state_t state, nstate;
  logic [7:0]  msg [4];
  logic [1:0]  idx;
  logic        start_q;
  logic        byte_busy;
  logic [7:0]  val8;

  always_ff @(posedge clk) begin
    if (rst) state <= L_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      L_IDLE:      if (send) nstate = L_LOAD;
      L_LOAD:      nstate = L_BYTE_WAIT;
      // start_q guards the cycle before the byte engine has registered the request
      L_BYTE_WAIT: if (!start_q && !byte_busy) nstate = (idx == 2'd3) ? L_FINISH : L_LOAD;
      L_FINISH:    nstate = L_IDLE;
      default:     nstate = L_IDLE;
    endcase
  end

  always_comb begin
    val8 = '0;
    val8[WIDTH-1:0] = value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      start_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) msg[i] <= '0;
    end else begin
      start_q <= (state == L_LOAD);
      if (state == L_IDLE && send) begin
        msg[0] <= nibble_to_hex(val8[7:4]);
        msg[1] <= nibble_to_hex(val8[3:0]);
        msg[2] <= ASCII_CR;
        msg[3] <= ASCII_LF;
        idx    <= '0;
      end else if (state == L_BYTE_WAIT && nstate == L_LOAD) begin
        idx <= idx + 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .data (msg[idx]),
    .start(start_q),
    .busy (byte_busy),
    .tx   (tx)
  );

  assign busy = (state == L_LOAD) || (state == L_BYTE_WAIT);
  assign done = (state == L_FINISH);

endmodule

// File: doc/led_value_uart_tx.md
Name: led_value_uart_tx

Overview:
- Reads the 5-bit LED counter value and reports it to the host over the icestick FTDI UART as one ASCII line: two uppercase hex digits, then CR LF (e.g. value 5'h1A -> "1A\r\n").
- Sits beside the LED counter in the top level. Host-side logging replaces watching LEDs.
- Transmit only, 8N1, LSB first. Line idles high.

Parameters:
- WIDTH, 5: width of the sampled value. Legal range 1..8; upper bits are zero-padded to 8 before hex encoding.
- CLKS_PER_BIT, 104: clk cycles per UART bit (12 MHz / 115200, truncated). Must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- value  in  WIDTH  counter value to report. Sampled only on an accepted send.
- send  in  1  request pulse or level. Accepted only when busy=0.
- busy  out  1  high from the cycle after acceptance until the line completes.
- done  out  1  one-cycle pulse in the cycle after the final LF stop bit ends.
- tx  out  1  UART serial output.

Behaviour:
- Interface (already decided): one clock, clk. rst is synchronous and active-high.
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0.
- rst asserted mid-frame:
  - next edge returns to IDLE with tx=1; the partial frame is abandoned.
  - no done pulse is emitted.
- Acceptance: in IDLE, send=1 at a clk edge:
  - latches value (zero-extended to 8 bits) into a 4-byte message: hex(hi nibble), hex(lo nibble), 8'h0D, 8'h0A.
  - sets busy=1 and byte index=0.
- Hex encoding: nibble 0-9 -> 8'h30+n; nibble A-F -> 8'h41+(n-10).
- Line FSM: IDLE -> LOAD -> BYTE_WAIT -> (index<3: LOAD, else FINISH) -> IDLE.
  - LOAD: issues one byte to the byte sub-module.
  - FINISH: pulses done, clears busy.
- Byte sub-module FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Latency: tx falls (start bit) 2 clk cycles after the accepting edge.
- Frame timing:
  - each byte is exactly 10*CLKS_PER_BIT cycles.
  - inter-byte gap: at most 2 cycles of idle-high between a stop bit and the next start bit.
  - whole line: 40*CLKS_PER_BIT + at most 8 cycles.
- Bit counter wraps CLKS_PER_BIT-1 -> 0. Bit index 0..7.
- send while busy=1 is ignored; nothing is queued.
- send held high continuously: a new line is accepted in the first IDLE cycle after done. Back-to-back lines are allowed.
- value may change at any time while busy; the transmitted message uses the latched copy.
- done and busy: done=1 coincides with the cycle busy falls to 0. A send in that same cycle is not accepted; it is accepted on the next cycle.

Decomposition:
- Shared package (uart_pkg):
  - line FSM and byte FSM state encodings.
  - ASCII constants: 8'h30, 8'h41, CR 8'h0D, LF 8'h0A.
  - function nibble_to_hex.
- Sub-module uart_tx_byte:
  - ports: clk, rst, data[7:0], start, busy, tx.
  - parameter: CLKS_PER_BIT.
  - contains the baud counter and shift register.
- led_value_uart_tx holds the message latch, the byte index and the line FSM.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release with send=0 -> tx=1, busy=0, done=0 for 100 cycles.
- Basic line, CLKS_PER_BIT=4, value=5'h1A, one-cycle send:
  - the UART decoder in the bench receives 8'h31, 8'h41, 8'h0D, 8'h0A in order.
  - each bit lasts 4 cycles.
  - done pulses exactly once, between 160 and 168 cycles after the send edge.
- Boundary values: value=0 -> "00\r\n"; value=31 -> "1F\r\n".
- Value change and busy gating:
  - value=5'h03; send; change value to 5'h1C at cycle 10.
  - extra send pulses at cycles 20 and 50.
  - required: the line is "03\r\n" and only one line is sent.
- send held high for 3 lines, value incrementing once per line, 7 -> 8 -> 9:
  - required lines "07", "08", "09" with CR LF.
  - no glitches on tx between lines.
- Reset mid-frame: rst=1 during the data bits of the second byte:
  - tx=1 on the next cycle, busy=0, no done.
  - a fresh send then produces a complete correct line.
